// File: rtl/bus_arbiter_pkg.sv
// Shared types and the round-robin search used by the bus arbiter.
// The search is sized for the largest supported master count; callers zero-extend.
package bus_arbiter_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_ID_W    = 3;

    // First requester strictly after last_grant, wrapping modulo masters.
    function automatic logic [MAX_ID_W-1:0] next_grant(
        input logic [MAX_MASTERS-1:0] requests,
        input logic [MAX_ID_W-1:0]    last_grant,
        input int                     masters
    );
        logic [MAX_ID_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = last_grant;
        found = 1'b0;
        for (int i = 1; i <= MAX_MASTERS; i++) begin
            if (i <= masters) begin
                idx = (int'(last_grant) + i) % masters;
                if (!found && requests[idx[MAX_ID_W-1:0]]) begin
                    pick  = idx[MAX_ID_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_arbiter_tag_fifo.sv
// In-order FIFO of issuing-master tags, one entry per read in flight.
// A push while full is dropped even if a pop happens in the same cycle.
module bus_arbiter_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one pipelined-read bus between MASTERS requesters.
// Read responses are routed back to the issuing master through an in-order tag FIFO.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MASTERS         = 2,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [MASTERS-1:0][ADDRESS_WIDTH-1:0]   masterAddress,
    input  logic [MASTERS-1:0]                      masterRead,
    input  logic [MASTERS-1:0]                      masterWrite,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]      masterWriteData,
    input  logic [MASTERS-1:0][DATA_WIDTH/8-1:0]    masterByteEnable,
    output logic [MASTERS-1:0]                      masterWaitRequest,
    output logic [MASTERS-1:0]                      masterReadValid,
    output logic [DATA_WIDTH-1:0]                   masterReadData,
    output logic [ADDRESS_WIDTH-1:0]                slaveAddress,
    output logic                                    slaveRead,
    output logic                                    slaveWrite,
    output logic [DATA_WIDTH-1:0]                   slaveWriteData,
    output logic [DATA_WIDTH/8-1:0]                 slaveByteEnable,
    input  logic                                    slaveWaitRequest,
    input  logic                                    slaveReadValid,
    input  logic [DATA_WIDTH-1:0]                   slaveReadData,
    output logic                                    busy,
    output logic                                    protocolError
);
    localparam int ID_W = $clog2(MASTERS);

    arb_state_t      state, state_next;
    logic [ID_W-1:0] owner, owner_next;
    logic [ID_W-1:0] last_grant, last_grant_next;
    logic [ID_W-1:0] picked;
    logic [ID_W-1:0] head;
    logic [MASTERS-1:0] requests;
    logic granted, own_read, own_write, rd_cmd, wr_cmd;
    logic owner_wait, accept, push, pop;
    logic fifo_full, fifo_empty;

    assign requests = masterRead | masterWrite;
    assign picked   = ID_W'(next_grant(MAX_MASTERS'(requests), MAX_ID_W'(last_grant), MASTERS));

    assign granted    = (state == GRANT);
    assign own_read   = masterRead[owner];
    assign own_write  = masterWrite[owner];
    // A read wins when the owner raises both strobes.
    assign rd_cmd     = granted & own_read;
    assign wr_cmd     = granted & own_write & ~own_read;
    assign owner_wait = slaveWaitRequest | (rd_cmd & fifo_full);
    assign accept     = (rd_cmd | wr_cmd) & ~owner_wait;
    assign push       = accept & rd_cmd;
    assign pop        = slaveReadValid & ~fifo_empty;

    assign slaveAddress    = masterAddress[owner];
    assign slaveWriteData  = masterWriteData[owner];
    assign slaveByteEnable = masterByteEnable[owner];
    assign slaveRead       = rd_cmd & ~fifo_full;
    assign slaveWrite      = wr_cmd;
    assign masterReadData  = slaveReadData;
    assign busy            = granted | ~fifo_empty;

    always_comb begin
        masterWaitRequest = '1;
        if (granted) masterWaitRequest[owner] = owner_wait;
    end

    always_comb begin
        masterReadValid = '0;
        if (pop) masterReadValid[head] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= '0;
            last_grant    <= ID_W'(MASTERS - 1);
            protocolError <= 1'b0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            if (slaveReadValid && fifo_empty) protocolError <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (|requests) begin
                    owner_next      = picked;
                    last_grant_next = picked;
                    state_next      = GRANT;
                end
            end
            GRANT: begin
                // Leave after every transfer, or when the owner gives up waiting.
                if (accept || !(own_read || own_write)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    bus_arbiter_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (owner),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus a randomized phase, all checked cycle by cycle against
// a transaction-level model (grant by round-robin search, response tags in a queue).
module tb_bus_arbiter;
    localparam int M  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [M-1:0][AW-1:0]   masterAddress;
    logic [M-1:0]           masterRead;
    logic [M-1:0]           masterWrite;
    logic [M-1:0][DW-1:0]   masterWriteData;
    logic [M-1:0][DW/8-1:0] masterByteEnable;
    logic [M-1:0]           masterWaitRequest;
    logic [M-1:0]           masterReadValid;
    logic [DW-1:0]          masterReadData;
    logic [AW-1:0]          slaveAddress;
    logic                   slaveRead;
    logic                   slaveWrite;
    logic [DW-1:0]          slaveWriteData;
    logic [DW/8-1:0]        slaveByteEnable;
    logic                   slaveWaitRequest;
    logic                   slaveReadValid;
    logic [DW-1:0]          slaveReadData;
    logic                   busy;
    logic                   protocolError;

    bus_arbiter #(
        .MASTERS(M), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .masterAddress(masterAddress), .masterRead(masterRead), .masterWrite(masterWrite),
        .masterWriteData(masterWriteData), .masterByteEnable(masterByteEnable),
        .masterWaitRequest(masterWaitRequest), .masterReadValid(masterReadValid),
        .masterReadData(masterReadData), .slaveAddress(slaveAddress),
        .slaveRead(slaveRead), .slaveWrite(slaveWrite), .slaveWriteData(slaveWriteData),
        .slaveByteEnable(slaveByteEnable), .slaveWaitRequest(slaveWaitRequest),
        .slaveReadValid(slaveReadValid), .slaveReadData(slaveReadData),
        .busy(busy), .protocolError(protocolError)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit m_granted;
    int m_owner;
    int m_last;
    int tags[$];
    bit m_perr;
    int acc_master;

    // Values seen at the most recent step
    logic [M-1:0]  obs_wait, obs_rv;
    logic          obs_sr, obs_sw, obs_busy, obs_perr;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_granted = 0;
        m_owner   = 0;
        m_last    = M - 1;
        tags.delete();
        m_perr    = 0;
    endtask

    // Called at posedge+1 with this cycle's inputs already driven.
    task automatic step();
        logic [M-1:0] e_wait, e_rv;
        bit e_sr, e_sw, full, rd, wr, acc, found;
        #3;
        e_wait = '1; e_rv = '0; e_sr = 0; e_sw = 0; acc = 0; rd = 0; wr = 0;
        full = (tags.size() == MO);
        if (m_granted) begin
            rd = masterRead[m_owner];
            wr = masterWrite[m_owner];
            e_sr = rd && !full;
            e_sw = wr && !rd;
            e_wait[m_owner] = slaveWaitRequest || (rd && full);
            acc = (rd || wr) && !e_wait[m_owner];
        end
        if (slaveReadValid && tags.size() > 0) e_rv[tags[0]] = 1'b1;

        obs_wait = masterWaitRequest; obs_rv = masterReadValid;
        obs_sr = slaveRead; obs_sw = slaveWrite; obs_busy = busy;
        obs_perr = protocolError; obs_addr = slaveAddress; obs_rdata = masterReadData;

        check("waitRequest", masterWaitRequest, e_wait);
        check("readValid", masterReadValid, e_rv);
        check("slaveRead", slaveRead, e_sr);
        check("slaveWrite", slaveWrite, e_sw);
        check("busy", busy, m_granted || tags.size() != 0);
        check("protocolError", protocolError, m_perr);
        if (m_granted && (rd || wr)) check("slaveAddress", slaveAddress, masterAddress[m_owner]);
        if (m_granted && e_sw) begin
            check("slaveWriteData", slaveWriteData, masterWriteData[m_owner]);
            check("slaveByteEnable", slaveByteEnable, masterByteEnable[m_owner]);
        end
        if (e_rv != '0) check("readData", masterReadData, slaveReadData);
        acc_master = acc ? m_owner : -1;

        if (slaveReadValid) begin
            if (tags.size() > 0) void'(tags.pop_front());
            else m_perr = 1;
        end
        if (m_granted) begin
            if (acc && rd) tags.push_back(m_owner);
            if (acc || !(rd || wr)) m_granted = 0;
        end else begin
            found = 0;
            for (int k = 1; k <= M; k++) begin
                int idx;
                idx = (m_last + k) % M;
                if (!found && (masterRead[idx] || masterWrite[idx])) begin
                    found = 1;
                    m_owner = idx;
                end
            end
            if (found) begin
                m_last = m_owner;
                m_granted = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #2;
        check("rst_waitRequest", masterWaitRequest, {M{1'b1}});
        check("rst_readValid", masterReadValid, '0);
        check("rst_slaveRead", slaveRead, 0);
        check("rst_slaveWrite", slaveWrite, 0);
        check("rst_busy", busy, 0);
        check("rst_protocolError", protocolError, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic issue(input int m, input bit is_read, input logic [AW-1:0] addr);
        bit done;
        masterAddress[m] = addr;
        masterRead[m]    = is_read;
        masterWrite[m]   = !is_read;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            step();
            if (acc_master == m) done = 1;
        end
        masterRead[m]  = 1'b0;
        masterWrite[m] = 1'b0;
        check("issue_accepted", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int grants[$];
        logic [AW-1:0] waddr;
        bit pend [M];

        masterAddress = '0; masterRead = '0; masterWrite = '0;
        masterWriteData = '0; masterByteEnable = '0;
        slaveWaitRequest = 0; slaveReadValid = 0; slaveReadData = '0;
        do_reset();

        // 1: lone read from master 0
        masterAddress[0] = 32'h100;
        masterRead[0] = 1'b1;
        step();
        check("t1_no_cmd_in_arb", obs_sr, 0);
        step();
        check("t1_slaveRead_cycle2", obs_sr, 1);
        check("t1_address", obs_addr, 32'h100);
        check("t1_accept", acc_master, 0);
        masterRead[0] = 1'b0;
        slaveReadValid = 1'b1;
        slaveReadData = 32'hCAFE;
        step();
        check("t1_readValid", obs_rv, 2'b01);
        check("t1_readData", obs_rdata, 32'hCAFE);
        slaveReadValid = 1'b0;
        step();

        // 2: continuous writes from both masters alternate
        do_reset();
        masterAddress[0] = 32'hA0; masterAddress[1] = 32'hB0;
        masterWriteData[0] = 32'h11; masterWriteData[1] = 32'h22;
        masterByteEnable[0] = 4'hF; masterByteEnable[1] = 4'h3;
        masterWrite = 2'b11;
        for (int c = 0; c < 8; c++) begin
            step();
            if (acc_master >= 0) begin
                grants.push_back(acc_master);
                check("t2_nonowner_wait", obs_wait[1 - acc_master], 1);
            end
        end
        masterWrite = '0;
        check("t2_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) check("t2_grant_order", grants[i], i % 2);
        step();

        // 3: five reads from master 1 with no responses
        n_acc = 0;
        masterAddress[1] = 32'h200;
        masterRead[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (acc_master == 1) begin
                n_acc++;
                masterAddress[1] = masterAddress[1] + 32'd4;
            end
        end
        check("t3_accepted_before_full", n_acc, 4);
        check("t3_fifth_stalled", obs_wait[1], 1);
        check("t3_no_read_when_full", obs_sr, 0);
        slaveReadValid = 1'b1;
        slaveReadData = 32'h1;
        step();
        check("t3_first_response", obs_rv, 2'b10);
        check("t3_push_blocked_on_pop", acc_master, -1);
        slaveReadValid = 1'b0;
        step();
        check("t3_fifth_accepted", acc_master, 1);
        masterRead[1] = 1'b0;
        slaveReadValid = 1'b1;
        for (int c = 0; c < 4; c++) step();
        slaveReadValid = 1'b0;
        step();
        check("t3_drained_idle", obs_busy, 0);

        // 4: interleaved reads return in issue order
        issue(0, 1, 32'h300);
        issue(1, 1, 32'h304);
        issue(0, 1, 32'h308);
        slaveReadValid = 1'b1;
        step(); check("t4_resp0", obs_rv, 2'b01);
        step(); check("t4_resp1", obs_rv, 2'b10);
        step(); check("t4_resp2", obs_rv, 2'b01);
        slaveReadValid = 1'b0;
        issue(1, 1, 32'h30C);
        masterAddress[0] = 32'h310;
        masterRead[0] = 1'b1;
        step();
        slaveReadValid = 1'b1;
        step();
        check("t4_push_pop_accept", acc_master, 0);
        check("t4_push_pop_strobe", obs_rv, 2'b10);
        masterRead[0] = 1'b0;
        slaveReadValid = 1'b0;
        step();
        slaveReadValid = 1'b1;
        step(); check("t4_last_tag", obs_rv, 2'b01);
        step(); check("t4_empty_no_strobe", obs_rv, 2'b00);
        slaveReadValid = 1'b0;
        step();
        check("t4_protocolError", obs_perr, 1);

        // 5: write held off by slaveWaitRequest
        do_reset();
        waddr = 32'h400;
        masterAddress[0] = waddr;
        masterWriteData[0] = 32'hDEADBEEF;
        masterByteEnable[0] = 4'h5;
        masterWrite[0] = 1'b1;
        slaveWaitRequest = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            check("t5_write_held", obs_sw, 1);
            check("t5_addr_stable", obs_addr, waddr);
            check("t5_not_accepted", acc_master, -1);
        end
        slaveWaitRequest = 1'b0;
        step();
        check("t5_accepted", acc_master, 0);
        masterWrite[0] = 1'b0;
        step();
        check("t5_no_tag", obs_busy, 0);

        // 6: reset with reads outstanding
        issue(0, 1, 32'h500);
        issue(0, 1, 32'h504);
        do_reset();
        slaveReadValid = 1'b1;
        step();
        check("t6_no_strobe", obs_rv, 2'b00);
        slaveReadValid = 1'b0;
        step();
        check("t6_protocolError", obs_perr, 1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < M; i++) pend[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < M; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    masterAddress[i] = $urandom;
                    masterWriteData[i] = $urandom;
                    masterByteEnable[i] = 4'($urandom_range(0, 15));
                    masterRead[i] = $urandom_range(0, 1) == 1;
                    masterWrite[i] = !masterRead[i] || ($urandom_range(0, 3) == 0);
                end
            end
            slaveWaitRequest = $urandom_range(0, 3) == 0;
            slaveReadValid = (tags.size() > 0) && ($urandom_range(0, 2) == 0);
            slaveReadData = $urandom;
            step();
            if (acc_master >= 0) begin
                pend[acc_master] = 0;
                masterRead[acc_master] = 1'b0;
                masterWrite[acc_master] = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
